// File: rtl/axis_rr_arbiter_pkg.sv
// axis_pkg: shared state type and round-robin pick function for the stream arbiter
package axis_pkg;
    typedef enum logic [0:0] {IDLE, PASS} arb_state_t;
    localparam int MAX_PORTS = 16;
    // Scan from lowest to highest priority so the port nearest after `last` wins.
    function automatic logic [3:0] rr_pick(input logic [MAX_PORTS-1:0] req, input logic [3:0] last, input int n);
        logic [3:0] idx;
        int p;
        idx = '0;
        for (int k = n; k >= 1; k--) begin
            p = (int'(last) + k) % n;
            if (req[4'(p)]) idx = 4'(p);
        end
        return idx;
    endfunction
endpackage

// File: rtl/axis_rr_arbiter_if.sv
// axis_rr_arbiter_if: NUM_PORTS slave streams plus the shared master stream
interface axis_rr_arbiter_if #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_PORTS-1:0]              s_tvalid, s_tready, s_tlast, s_tuser;
    logic [NUM_PORTS*DATA_WIDTH-1:0]   s_tdata;
    logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_tstrb;
    logic                              m_tvalid, m_tready, m_tlast, m_tuser;
    logic [DATA_WIDTH-1:0]             m_tdata;
    logic [DATA_WIDTH/8-1:0]           m_tstrb;
    modport master (
        input  s_tvalid, s_tdata, s_tstrb, s_tlast, s_tuser, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tstrb, m_tlast, m_tuser
    );
    modport slave (
        output s_tvalid, s_tdata, s_tstrb, s_tlast, s_tuser, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tstrb, m_tlast, m_tuser
    );
endinterface

// File: rtl/axis_rr_arbiter_sel.sv
// rr_priority_sel: combinational round-robin selector over the request vector
module rr_priority_sel
    import axis_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    localparam int GW        = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [GW-1:0]        i_last,
    output logic [GW-1:0]        o_idx,
    output logic                 o_any
);
    assign o_idx = GW'(rr_pick(MAX_PORTS'(i_req), 4'(i_last), NUM_PORTS));
    assign o_any = |i_req;
endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-granular round-robin mux of NUM_PORTS AXI-Stream inputs onto one output
module axis_rr_arbiter
    import axis_pkg::*;
#(
    parameter  int NUM_PORTS  = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int CNT_WIDTH  = 16,
    localparam int GW         = $clog2(NUM_PORTS),
    localparam int SW         = DATA_WIDTH / 8
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    axis_rr_arbiter_if.master    bus,
    output logic [GW-1:0]        grant_id,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] pkt_count
);
    arb_state_t           r_state, w_next;
    logic [GW-1:0]        r_grant, r_last, w_idx;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 w_any, w_eop;

    rr_priority_sel #(.NUM_PORTS(NUM_PORTS)) u_sel (
        .i_req  (bus.s_tvalid),
        .i_last (r_last),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    always_comb begin
        bus.s_tready = '0;
        bus.m_tvalid = 1'b0;
        bus.m_tdata  = '0;
        bus.m_tstrb  = '0;
        bus.m_tlast  = 1'b0;
        bus.m_tuser  = 1'b0;
        if (r_state == PASS) begin
            bus.m_tvalid          = bus.s_tvalid[r_grant];
            bus.m_tdata           = bus.s_tdata[r_grant*DATA_WIDTH +: DATA_WIDTH];
            bus.m_tstrb           = bus.s_tstrb[r_grant*SW +: SW];
            bus.m_tlast           = bus.s_tlast[r_grant];
            bus.m_tuser           = bus.s_tuser[r_grant];
            bus.s_tready[r_grant] = bus.m_tready;
        end
        w_eop  = (r_state == PASS) && bus.m_tvalid && bus.m_tready && bus.m_tlast;
        w_next = (r_state == IDLE) ? (w_any ? PASS : IDLE) : (w_eop ? IDLE : PASS);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= GW'(NUM_PORTS - 1);
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_any) r_grant <= w_idx;
            if (w_eop) begin
                r_last <= r_grant;
                r_cnt  <= (&r_cnt) ? r_cnt : r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign grant_id  = r_grant;
    assign busy      = (r_state == PASS);
    assign pkt_count = r_cnt;
endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Packet-granular round-robin arbiter that shares one AXI-Stream master port among NUM_PORTS AXI-Stream requesters. It sits in front of the DMA write-side stream FIFO. Multiple producers (channel engines, descriptor status writer) each present a stream, and the arbiter forwards whole packets, one at a time, to the single downstream consumer. A grant is held from a packet's first beat through its TLAST beat, so packets are never interleaved.

## Interface
Parameters:
- NUM_PORTS, 4: number of slave stream ports; legal range 2–16.
- DATA_WIDTH, 32: TDATA width in bits; must be a multiple of 8.
- CNT_WIDTH, 16: width of the packet counter.

Ports:
- ACLK  in  1  single clock; all logic is on its rising edge.
- ARESET  in  1  synchronous, active-high reset.
- s_tvalid  in  NUM_PORTS  per-port TVALID.
- s_tready  out  NUM_PORTS  per-port TREADY.
- s_tdata  in  NUM_PORTS*DATA_WIDTH  per-port TDATA; port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- s_tstrb  in  NUM_PORTS*DATA_WIDTH/8  per-port TSTRB.
- s_tlast  in  NUM_PORTS  per-port TLAST.
- s_tuser  in  NUM_PORTS  per-port TUSER.
- m_tvalid, m_tdata, m_tstrb, m_tlast, m_tuser  out  1 / DATA_WIDTH / DATA_WIDTH/8 / 1 / 1  master stream.
- m_tready  in  1  master TREADY.
- grant_id  out  $clog2(NUM_PORTS)  index of the current or last granted port.
- busy  out  1  high while in the PASS state.
- pkt_count  out  CNT_WIDTH  number of completed packets; saturates at all-ones.

## Operation
- The FSM has two states, IDLE and PASS.
- IDLE:
  - All s_tready are 0 and m_tvalid is 0.
  - If any s_tvalid is 1, the arbiter selects the first requesting port, searching upward from (last_grant+1) mod NUM_PORTS and wrapping.
  - It registers that port into grant_id and moves to PASS on the next edge.
- PASS:
  - m_tvalid/m_tdata/m_tstrb/m_tlast/m_tuser are combinational copies of slave port grant_id.
  - s_tready[grant_id] = m_tready; every other s_tready is 0.
  - A beat transfers when m_tvalid and m_tready are both 1.
- End of packet: a transfer with m_tlast = 1 returns the FSM to IDLE, sets last_grant = grant_id, and increments pkt_count (saturating).
- Requests are sampled only in IDLE. A port raising TVALID during PASS waits for the next arbitration.
- The granted port may drop TVALID mid-packet. The grant is held with no timeout until that port's TLAST transfer completes.
- Fairness: with all ports continuously requesting, grants rotate 0,1,2,…,NUM_PORTS-1,0.

## Timing
- Reset values:
  - state = IDLE.
  - last_grant = NUM_PORTS-1, so port 0 wins the first arbitration.
  - grant_id = 0, busy = 0, pkt_count = 0.
  - All s_tready = 0 and m_tvalid = 0.
- Arbitration latency: a request seen in IDLE at edge N produces PASS, and a valid m_tvalid, from the cycle after edge N.
- The data path adds zero cycles of latency in PASS; master outputs follow slave inputs within the same cycle.
- There is exactly one idle bubble cycle between consecutive packets, spent in IDLE.
- A single-beat packet (TLAST on the first beat) occupies PASS for one cycle when m_tready = 1.
- Back-pressure: m_tready = 0 stalls the granted port only. The state and grant do not change.
- ARESET asserted during PASS forces IDLE on the next edge and drops all s_tready. A partially forwarded packet is truncated; recovery is upstream's responsibility.
- When NUM_PORTS is not a power of two, grant_id values ≥ NUM_PORTS never occur.

## Structure
- Shared package axis_pkg holds:
  - typedef enum logic [0:0] {IDLE, PASS} arb_state_t;
  - the function rr_pick(req, last) returning the next grant index.
- One sub-module is natural: rr_priority_sel, a combinational round-robin selector that takes req[NUM_PORTS] and last, and returns idx and any.
- The top level holds the FSM, the grant/last_grant registers, the output mux and the counter.

## Test plan
- Reset release, then s_tvalid = 4'b0101 with 3-beat packets: port 0 is granted first and its 3 beats appear on m_* in order with TLAST on beat 3. One idle cycle follows, then port 2 is granted. pkt_count = 2.
- All four ports request continuously with 1-beat packets and m_tready = 1: grant_id sequence is 0,1,2,3,0,1. m_tvalid alternates 1,0 (bubble). No s_tready is raised for a non-granted port.
- Port 1 is granted. m_tready toggles 1,0,0,1 and port 1 drops TVALID for 2 cycles mid-packet: no beats are lost or duplicated, grant stays 1, and port 3 requesting meanwhile waits until after TLAST.
- ARESET pulsed for 1 cycle during beat 2 of a 4-beat packet: the next cycle shows state IDLE, s_tready = 0, pkt_count = 0, and a fresh arbitration grants port 0.
- CNT_WIDTH = 4 with 20 packets sent: pkt_count holds at 15.
- NUM_PORTS = 3 with only port 2 requesting, 3 packets: grant_id = 2 each time and never exceeds 2.
